// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: conditions the raw lines, deframes bytes, assembles 3-byte packets and
// accumulates clamped screen coordinates. Define PS2_SENS_DIV_EN to halve motion sensitivity.
module ps2_mouse_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int X_MIN          = 5,
    parameter int X_MAX          = 639,
    parameter int Y_MIN          = 5,
    parameter int Y_MAX          = 479,
    parameter int X_RESET        = 360,
    parameter int Y_RESET        = 200
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic       packet_valid,
    output logic       frame_err
);
    localparam int FCNT_W = $clog2(FILTER_LEN) + 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0] line_raw;
    logic [1:0] line_filt;
    assign line_raw = {ps2_data, ps2_clk};

    // Index 0 is the PS/2 clock, index 1 the data line; both see identical latency.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [1:0]        sync_q, sync_d;
            logic              filt_q, filt_d;
            logic [FCNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                sync_d = {sync_q[0], line_raw[gi]};
                filt_d = filt_q;
                cnt_d  = '0;
                if (sync_q[1] != filt_q) begin
                    if (cnt_q == FCNT_W'(FILTER_LEN - 1)) filt_d = sync_q[1];
                    else                                  cnt_d  = cnt_q + FCNT_W'(1);
                end
            end

            always_ff @(posedge clk_in) begin
                if (!rst_in_n) begin
                    sync_q <= 2'b11;
                    filt_q <= 1'b1;
                    cnt_q  <= '0;
                end else begin
                    sync_q <= sync_d;
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign line_filt[gi] = filt_q;
        end
    endgenerate

    state_t           state_q, state_d;
    logic             clk_prev_q, clk_prev_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [6:0]       hdr_q, hdr_d;      // {Yovf, Xovf, Ys, Xs, M, R, L}
    logic [7:0]       xbyte_q, xbyte_d;
    logic [9:0]       x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic [2:0]       btn_q, btn_d;
    logic             packet_valid_q, packet_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             strobe, din, byte_done;
    logic signed [8:0]  dx, dy;
    logic signed [10:0] nx, ny;
    logic [9:0]         x_new, y_new;

    assign clk_prev_d = line_filt[0];
    assign strobe     = clk_prev_q & ~line_filt[0];
    assign din        = line_filt[1];

    // The Y byte is still in the shift register when the third byte completes.
    always_comb begin
        dx = hdr_q[5] ? 9'sd0 : $signed({hdr_q[3], xbyte_q});
        dy = hdr_q[6] ? 9'sd0 : $signed({hdr_q[4], shift_q});
`ifdef PS2_SENS_DIV_EN
        dx = dx >>> 1;
        dy = dy >>> 1;
`endif
        nx = $signed({1'b0, x_pos_q}) + $signed({{2{dx[8]}}, dx});
        ny = $signed({1'b0, y_pos_q}) - $signed({{2{dy[8]}}, dy});
        x_new = (nx < X_MIN_S) ? 10'(X_MIN) : (nx > X_MAX_S) ? 10'(X_MAX) : nx[9:0];
        y_new = (ny < Y_MIN_S) ? 10'(Y_MIN) : (ny > Y_MAX_S) ? 10'(Y_MAX) : ny[9:0];
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        par_ok_d       = par_ok_q;
        tmo_d          = '0;
        byte_idx_d     = byte_idx_q;
        hdr_d          = hdr_q;
        xbyte_d        = xbyte_q;
        x_pos_d        = x_pos_q;
        y_pos_d        = y_pos_q;
        btn_d          = btn_q;
        packet_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        byte_done      = 1'b0;

        if (state_q != S_IDLE && !strobe) begin
            if (tmo_q >= TMO_W'(TIMEOUT_CYCLES)) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
                byte_idx_d  = 2'd0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        if (strobe) begin
            case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_ok_d = ^{shift_q, din};
                    state_d  = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (din && par_ok_q) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        byte_idx_d  = 2'd0;
                    end
                end
            endcase
        end

        if (byte_done) begin
            case (byte_idx_q)
                2'd0: begin
                    if (shift_q[3]) begin
                        hdr_d      = {shift_q[7:4], shift_q[2:0]};
                        byte_idx_d = 2'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                2'd1: begin
                    xbyte_d    = shift_q;
                    byte_idx_d = 2'd2;
                end
                default: begin
                    x_pos_d        = x_new;
                    y_pos_d        = y_new;
                    btn_d          = hdr_q[2:0];
                    packet_valid_d = 1'b1;
                    byte_idx_d     = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state_q        <= S_IDLE;
            clk_prev_q     <= 1'b1;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'd0;
            par_ok_q       <= 1'b0;
            tmo_q          <= '0;
            byte_idx_q     <= 2'd0;
            hdr_q          <= 7'd0;
            xbyte_q        <= 8'd0;
            x_pos_q        <= 10'(X_RESET);
            y_pos_q        <= 10'(Y_RESET);
            btn_q          <= 3'd0;
            packet_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_prev_q     <= clk_prev_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            par_ok_q       <= par_ok_d;
            tmo_q          <= tmo_d;
            byte_idx_q     <= byte_idx_d;
            hdr_q          <= hdr_d;
            xbyte_q        <= xbyte_d;
            x_pos_q        <= x_pos_d;
            y_pos_q        <= y_pos_d;
            btn_q          <= btn_d;
            packet_valid_q <= packet_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign x_pos        = x_pos_q;
    assign y_pos        = y_pos_q;
    assign btn_left     = btn_q[0];
    assign btn_right    = btn_q[1];
    assign btn_middle   = btn_q[2];
    assign packet_valid = packet_valid_q;
    assign frame_err    = frame_err_q;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: drives PS/2 frames and checks every output cycle against
// an integer-level packet model, plus literal position checkpoints.
module tb_ps2_mouse_rx;
    localparam int TMO  = 1000;
    localparam int HALF = 20;
    localparam int GAP  = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] x_pos, y_pos;
    logic       btn_left, btn_right, btn_middle, packet_valid, frame_err;

    ps2_mouse_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk), .rst_in_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .x_pos(x_pos), .y_pos(y_pos), .btn_left(btn_left), .btn_right(btn_right),
        .btn_middle(btn_middle), .packet_valid(packet_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {bit err; int x; int y; bit [2:0] btn;} ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    // Model state: packet assembly and position as plain integers
    int       m_idx, m_x, m_y;
    bit [7:0] m_hdr, m_xb;
    // Last position/buttons the model said the DUT should be showing
    int       cur_x, cur_y;
    bit [2:0] cur_btn;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic push_err();
        ev_t e;
        e.err = 1; e.x = 0; e.y = 0; e.btn = 0;
        exp_q.push_back(e);
        m_idx = 0;
    endtask

    task automatic model_byte(input bit [7:0] b);
        ev_t e;
        int dx, dy;
        if (m_idx == 0) begin
            if (b[3]) begin m_hdr = b; m_idx = 1; end
            else push_err();
        end else if (m_idx == 1) begin
            m_xb = b; m_idx = 2;
        end else begin
            dx = m_hdr[6] ? 0 : (m_hdr[4] ? int'(m_xb) - 256 : int'(m_xb));
            dy = m_hdr[7] ? 0 : (m_hdr[5] ? int'(b) - 256 : int'(b));
            m_x = clampi(m_x + dx, 5, 639);
            m_y = clampi(m_y - dy, 5, 479);
            e.err = 0; e.x = m_x; e.y = m_y; e.btn = {m_hdr[2], m_hdr[1], m_hdr[0]};
            exp_q.push_back(e);
            m_idx = 0;
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            n_checks++;
            if (packet_valid && frame_err) begin
                n_fail++;
                $display("FAIL pulses: packet_valid and frame_err both 1, required at most one");
            end else if (packet_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: pv=%0b fe=%0b with no event expected", packet_valid, frame_err);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.err != frame_err) begin
                        n_fail++;
                        $display("FAIL event_kind: got frame_err=%0b required %0b", frame_err, e.err);
                    end else if (!e.err) begin
                        cur_x = e.x; cur_y = e.y; cur_btn = e.btn;
                    end
                end
            end
            if (int'(x_pos) != cur_x || int'(y_pos) != cur_y ||
                {btn_middle, btn_right, btn_left} != cur_btn) begin
                n_checks++;
                n_fail++;
                $display("FAIL outputs: got x=%0d y=%0d btn=%b required x=%0d y=%0d btn=%b",
                         x_pos, y_pos, {btn_middle, btn_right, btn_left}, cur_x, cur_y, cur_btn);
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input bit [7:0] b, input bit bad_par);
        if (bad_par) push_err();
        else         model_byte(b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
        $display("frame 0x%02h bad_par=%0b -> x=%0d y=%0d", b, bad_par, x_pos, y_pos);
    endtask

    task automatic send_pkt(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2);
        send_frame(b0, 0);
        send_frame(b1, 0);
        send_frame(b2, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_lit(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
        $display("check %s = %0d", name, got);
    endtask

    task automatic do_reset();
        checking = 0;
        @(negedge clk);
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_idx = 0; m_x = 360; m_y = 200; m_hdr = 0; m_xb = 0;
        cur_x = 360; cur_y = 200; cur_btn = 3'b000;
        check_lit("reset_x", int'(x_pos), 360);
        check_lit("reset_y", int'(y_pos), 200);
        check_lit("reset_btn", int'({btn_middle, btn_right, btn_left}), 0);
        check_lit("reset_pulses", int'({packet_valid, frame_err}), 0);
        repeat (20) @(negedge clk);
        checking = 1;
    endtask

    initial begin
        do_reset();

        send_pkt(8'h09, 8'h0A, 8'h05);
        drain();
        check_lit("basic_x", int'(x_pos), 370);
        check_lit("basic_y", int'(y_pos), 195);
        check_lit("basic_left", int'(btn_left), 1);

        do_reset();
        send_pkt(8'h38, 8'h80, 8'h80); drain();
        check_lit("neg1_x", int'(x_pos), 232); check_lit("neg1_y", int'(y_pos), 328);
        send_pkt(8'h38, 8'h80, 8'h80); drain();
        check_lit("neg2_x", int'(x_pos), 104); check_lit("neg2_y", int'(y_pos), 456);
        send_pkt(8'h38, 8'h80, 8'h80); drain();
        check_lit("neg3_x", int'(x_pos), 5);   check_lit("neg3_y", int'(y_pos), 479);

        send_frame(8'h08, 0);
        send_frame(8'h0A, 1);
        send_pkt(8'h09, 8'h0A, 8'h05);
        drain();
        check_lit("after_parity_x", int'(x_pos), 15);
        check_lit("after_parity_y", int'(y_pos), 474);

        send_frame(8'h00, 0);
        send_pkt(8'h48, 8'h10, 8'h10);
        drain();
        check_lit("xovf_x", int'(x_pos), 15);
        check_lit("xovf_y", int'(y_pos), 458);
        check_lit("xovf_btn", int'({btn_middle, btn_right, btn_left}), 0);

        // Start bit plus three data bits, then the clock stalls high.
        push_err();
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TMO + 200) @(negedge clk);
        drain();
        send_pkt(8'h2A, 8'h20, 8'hF0);
        drain();
        check_lit("after_tmo_x", int'(x_pos), 47);
        check_lit("after_tmo_y", int'(y_pos), 474);
        check_lit("after_tmo_right", int'(btn_right), 1);

        send_pkt(8'h1C, 8'hF6, 8'h64);
        drain();
        check_lit("mid_x", int'(x_pos), 37);
        check_lit("mid_y", int'(y_pos), 374);
        check_lit("mid_middle", int'(btn_middle), 1);

        for (int i = 0; i < 5; i++) send_pkt(8'h08, 8'h7F, 8'h00);
        drain();
        check_lit("xmax_clamp", int'(x_pos), 639);
        for (int i = 0; i < 3; i++) send_pkt(8'h08, 8'h00, 8'h7F);
        drain();
        check_lit("ymin_clamp", int'(y_pos), 5);

        repeat (50) @(negedge clk);
        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_mouse_rx.md
Name: ps2_mouse_rx

Overview:
- Receives the PS/2 device-to-host stream from a physical mouse and decodes standard 3-byte movement packets.
- Accumulates the decoded motion into absolute screen coordinates x_pos/y_pos, clamped to the visible area.
- Drops into the cursor datapath in place of the button-driven mouse simulator, with the same coordinate outputs, reset position and bounds.
- Host-to-device transmission is out of scope: the mouse is already in stream mode.

Parameters:
- FILTER_LEN, 8: consecutive identical clk_in samples required before the filtered ps2_clk/ps2_data change state.
- TIMEOUT_CYCLES, 50000: clk_in cycles allowed between ps2_clk falling edges inside a frame (1 ms at 50 MHz).
- X_MIN, 5 / X_MAX, 639: x_pos clamp bounds, inclusive.
- Y_MIN, 5 / Y_MAX, 479: y_pos clamp bounds, inclusive.
- X_RESET, 360 / Y_RESET, 200: position after reset.

Ports:
- clk_in, input, 1: system clock, all logic on its rising edge.
- rst_in_n, input, 1: synchronous active-low reset.
- ps2_clk, input, 1: PS/2 clock line, asynchronous.
- ps2_data, input, 1: PS/2 data line, asynchronous.
- x_pos, output, 10: cursor column.
- y_pos, output, 10: cursor row, 0 = top.
- btn_left / btn_right / btn_middle, output, 1 each: button state from the last valid packet.
- packet_valid, output, 1: one-cycle pulse when a packet has been applied.
- frame_err, output, 1: one-cycle pulse on parity, start, stop, timeout or sync error.

Behaviour:
- Reset, when rst_in_n = 0 at a rising clk_in edge:
  - x_pos = X_RESET, y_pos = Y_RESET.
  - All buttons, packet_valid and frame_err = 0.
  - FSM to IDLE, byte index = 0, synchronisers and filters preset to 1.
  - Reset mid-frame or mid-packet discards all partial data.
- Input conditioning:
  - Two-flop synchroniser per line, then a FILTER_LEN stable-count filter.
  - Falling edge of the filtered ps2_clk produces a one-cycle strobe; data is sampled from filtered ps2_data on that strobe.
- Frame FSM, IDLE -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: strobe with data 0 goes to DATA with bit counter = 0. Strobe with data 1 pulses frame_err and stays in IDLE.
  - DATA: shift in 8 bits, LSB first; after the 8th bit go to PARITY.
  - PARITY: 8 data bits plus parity must have odd weight.
  - STOP: stop bit must be 1. A good byte yields a byte-done strobe; parity or stop failure pulses frame_err and returns to IDLE with byte index cleared.
  - Timeout: in DATA, PARITY or STOP, more than TIMEOUT_CYCLES between strobes pulses frame_err, returns to IDLE and clears byte index. The timeout counter restarts on every strobe.
- Packet assembly, byte index 0..2:
  - Byte 0 bit 3 must be 1. Otherwise discard the byte, pulse frame_err and keep index at 0 (resync).
  - Byte 0 fields: bit0 L, bit1 R, bit2 M, bit4 Xs, bit5 Ys, bit6 Xovf, bit7 Yovf.
  - Byte 1 = X[7:0], byte 2 = Y[7:0].
- Update on the byte-done strobe of byte 2, cycle N. At cycle N+1, in the same cycle:
  - x_pos, y_pos and the buttons are registered and packet_valid = 1.
  - Byte index returns to 0.
- Arithmetic:
  - dx = signed 9-bit {Xs, X}; dy = signed 9-bit {Ys, Y}.
  - If Xovf = 1, dx = 0; if Yovf = 1, dy = 0. Buttons still update.
  - nx = x_pos + dx and ny = y_pos - dy, both computed as 11-bit signed. PS/2 +Y is up; screen rows increase downward.
  - Each result is clamped to [MIN, MAX] before registering, so no 10-bit wrap can occur.
- Simultaneous events:
  - Reset dominates everything.
  - Timeout and strobe in the same cycle: the strobe wins and the timeout counter clears.
  - Outputs are glitch-free registers; packet_valid and frame_err are never asserted in the same cycle.

Optional Feature:
- PS2_SENS_DIV_EN defined: after overflow masking, dx and dy are arithmetically right-shifted by 1 (half sensitivity; -1 stays -1, +1 becomes 0). Clamping is unchanged.
- PS2_SENS_DIV_EN undefined: dx and dy are applied unscaled. No extra logic or latency in either case.

Test Plan:
- Reset: hold rst_in_n = 0 for 3 cycles, release -> x_pos = 360, y_pos = 200, all buttons 0, no pulses.
- Basic move: send packet 0x09, 0x0A, 0x05 (L pressed, dx = +10, dy = +5) -> one packet_valid pulse; x_pos = 370, y_pos = 195, btn_left = 1.
- Negative move and clamp: send 0x38, 0x80, 0x80 (dx = -128, dy = -128) three times from reset.
  - x: 360 -> 232 -> 104 -> 5.
  - y: 200 -> 328 -> 456 -> 479.
- Parity error: corrupt the parity bit of byte 1 -> frame_err pulse, no packet_valid. The next clean 3-byte packet decodes correctly.
- Resync and overflow:
  - Send a lone byte 0x00 -> frame_err pulse, index stays 0.
  - Then send 0x48, 0x10, 0x10 (Xovf set) -> x_pos unchanged, y_pos decreases by 16.
- Timeout: stop ps2_clk after the start and 3 data bits for TIMEOUT_CYCLES+1 cycles -> frame_err pulse, FSM back to IDLE. The next full packet is accepted.
